serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder built around the one-bit full adder cell, which it instantiates as its combinational core. The block is the sequential stage that feeds that cell. It latches two operands and a carry-in on a start handshake, then presents one bit pair per clock to the full adder, LSB first. A registered carry closes the loop, and the sum bits are shifted into a result register. It trades WIDTH cycles of latency for a single adder cell, for area-constrained datapaths.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the single clock domain.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- start  input  1  request to begin an addition; honoured only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- busy  output  1  high while bits are being processed (state SHIFT).
- done  output  1  one-cycle pulse marking that sum and cout are valid.
- sum  output  WIDTH  result register, a+b+cin modulo 2^WIDTH.
- cout  output  1  carry-out of bit WIDTH-1.

## Operation
- Internal registers:
  - a_sh, b_sh: WIDTH-bit operand shift registers.
  - sum_sh: WIDTH-bit result shift register, driving sum.
  - carry: 1-bit carry register, driving cout.
  - cnt: bit counter, clog2(WIDTH) bits.
  - state: FSM state register.
- Full adder connection: inputs are a_sh[0], b_sh[0] and carry; outputs are s_bit and c_bit.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum_sh<=0, next state SHIFT.
  - Otherwise all registers hold, so sum and cout keep the last result.
- SHIFT:
  - busy=1.
  - Every cycle: sum_sh<={s_bit, sum_sh[WIDTH-1:1]}, a_sh<=a_sh>>1, b_sh<=b_sh>>1, carry<=c_bit, cnt<=cnt+1.
  - When cnt==WIDTH-1, next state DONE. This is the last bit, and it is still processed in this cycle.
- DONE:
  - done=1, busy=0; sum and cout are final.
  - Next state is unconditionally IDLE.
  - start is ignored here; it is not queued.
- start while in SHIFT or DONE: ignored, with no effect on any register.
- Arithmetic:
  - {cout,sum} equals the (WIDTH+1)-bit value a+b+cin of the accepted operands.
  - No overflow flag; cout is the only overflow indication.
- Operand changes after the accepting edge have no effect, because operands are captured.
- Reset (any state, including mid-SHIFT):
  - state<=IDLE.
  - a_sh, b_sh, sum_sh, carry, cnt <= 0.
  - Any operation in flight is discarded, with no done pulse.
- Reset values of outputs: busy=0, done=0, sum=0, cout=0.
- sum and cout are intermediate and unspecified while busy=1. They are valid in the done cycle and stay stable through IDLE until the next accepted start.

## Timing
- Edge E0: start accepted in IDLE.
- Cycles E0+1 .. E0+WIDTH: busy=1, for exactly WIDTH cycles.
- Cycle E0+WIDTH+1: done=1 for exactly one cycle, with sum and cout valid.
- Earliest next acceptance is edge E0+WIDTH+2; the throughput is one addition per WIDTH+2 cycles.
- Every output is a registered state or datapath bit; there is no combinational input-to-output path.
- If rst and start are asserted on the same edge, rst wins and the block stays in IDLE.

## Test plan
- Reset: assert rst for 2 cycles -> busy=0, done=0, sum=0, cout=0. Then release rst, apply start=1 with a=8'h12, b=8'h34, cin=0 -> busy high for 8 cycles, then done with sum=8'h46, cout=0.
- Carry ripple: a=8'hFF, b=8'h01, cin=0 -> done at E0+9 with sum=8'h00, cout=1. Also a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
- Ignored start:
  - pulse start with a=8'h01, b=8'h01 during cycle E0+4 -> result of the first operation unchanged, no extra done pulse;
  - start held high through the DONE cycle -> accepted only at the following IDLE edge, with done pulses exactly WIDTH+2 cycles apart.
- Reset mid-operation: assert rst at E0+5 -> next cycle busy=0, sum=0, cout=0, and no done pulse ever appears. A fresh start afterwards completes normally.
- Operand change: change a and b at E0+1..E0+WIDTH -> result still reflects the values captured at E0.
- Random: 1000 random a, b, cin at WIDTH=8 and WIDTH=16 -> {cout,sum}==a+b+cin at every done pulse, and done always lands exactly WIDTH+1 cycles after acceptance.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder cell fed LSB-first from operand shift
// registers, with a registered carry closing the loop and sum bits shifted
// into a result register. WIDTH+2 cycles per addition including handshake.

// One-bit full adder cell: the combinational core of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              s_bit, c_bit;

    full_adder u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (s_bit),
        .co (c_bit)
    );

    // Next-state and datapath update; every register holds unless its state acts on it.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                sum_sh_d = {s_bit, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = c_bit;
                cnt_d    = cnt_q + CntW'(1);
                // The last bit is still processed on the transition edge.
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that discards any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs are pure decodes of registered state and datapath bits.
    always_comb begin
        busy = (state_q == StShift);
        done = (state_q == StDone);
        sum  = sum_sh_q;
        cout = carry_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16.
// Expected results come from plain (WIDTH+1)-bit arithmetic a+b+cin.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst, start, cin;
    logic [7:0]  a, b;
    logic        busy, done, cout;
    logic [7:0]  sum;

    logic        start16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one 8-bit addition from IDLE and waits (bounded) for done.
    // lat counts edges from the accepting edge to the first done sample.
    task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          input bit scramble, input bit inject,
                          output logic [8:0] res, output int lat, output int busy_n,
                          output bit timeout);
        a = ia; b = ib; cin = ic; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0; busy_n = 0; timeout = 1'b0;
        while (!done) begin
            if (busy) busy_n++;
            if (scramble) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end
            if (inject && lat == 3) begin
                a = 8'h01; b = 8'h01; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
            if (lat > 50) begin
                timeout = 1'b1;
                break;
            end
        end
        start = 1'b0;
        res = {cout, sum};
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        tick(); tick();
        tests_run++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy, done, sum, cout);
        end
        // rst and start on the same edge: rst wins
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_beats_start: got busy=%b done=%b, want 0 0", busy, done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [8:0] res; int lat, bn; bit to;
        do_op8(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, res, lat, bn, to);
        tests_run++;
        if (to || res !== 9'h046) begin
            fails++;
            $display("FAIL basic_sum: got %h (timeout=%0d), want 046", res, to);
        end
        tests_run++;
        if (bn !== 8 || lat !== 8) begin
            fails++;
            $display("FAIL basic_timing: got busy_cycles=%0d done_edge=%0d, want 8 8", bn, lat);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || {cout, sum} !== 9'h046) begin
            fails++;
            $display("FAIL basic_hold: got done=%b result=%h, want 0 046", done, {cout, sum});
        end
    endtask

    task automatic test_carry_ripple();
        logic [8:0] res; int lat, bn; bit to;
        do_op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, res, lat, bn, to);
        tests_run++;
        if (to || res !== 9'h100) begin
            fails++;
            $display("FAIL ripple_ff_01: got %h, want 100", res);
        end
        tick();
        do_op8(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, res, lat, bn, to);
        tests_run++;
        if (to || res !== 9'h100) begin
            fails++;
            $display("FAIL ripple_a5_5a_c1: got %h, want 100", res);
        end
        tick();
    endtask

    task automatic test_ignored_start();
        logic [8:0] res; int lat, bn, extra; bit to;
        do_op8(8'h3C, 8'h44, 1'b0, 1'b0, 1'b1, res, lat, bn, to);
        tests_run++;
        if (to || res !== 9'h080 || lat !== 8) begin
            fails++;
            $display("FAIL start_in_shift: got %h lat=%0d, want 080 lat=8", res, lat);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) extra++;
        end
        tests_run++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL no_extra_done: got %0d active cycles, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, n;
        logic [8:0] r2;
        a = 8'h70; b = 8'h91; cin = 1'b1; start = 1'b1;
        t1 = -1; t2 = -1; n = 0; r2 = '0;
        while (t2 < 0 && n < 60) begin
            tick();
            n++;
            if (done) begin
                if (t1 < 0) t1 = n;
                else begin
                    t2 = n;
                    r2 = {cout, sum};
                end
            end
        end
        start = 1'b0;
        tests_run++;
        if (t1 < 0 || t2 < 0 || (t2 - t1) !== 10) begin
            fails++;
            $display("FAIL back_to_back_spacing: got first=%0d second=%0d, want spacing 10",
                     t1, t2);
        end
        tests_run++;
        if (r2 !== 9'h102) begin
            fails++;
            $display("FAIL back_to_back_sum: got %h, want 102", r2);
        end
        tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        logic [8:0] res; int lat, bn, seen; bit to;
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_op: got busy=%b sum=%h cout=%b, want 0 00 0",
                     busy, sum, cout);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", seen);
        end
        do_op8(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, res, lat, bn, to);
        tests_run++;
        if (to || res !== 9'h101) begin
            fails++;
            $display("FAIL reset_mid_fresh: got %h, want 101", res);
        end
        tick();
    endtask

    task automatic test_operand_change();
        logic [8:0] res; int lat, bn; bit to;
        do_op8(8'hC3, 8'h6E, 1'b1, 1'b1, 1'b0, res, lat, bn, to);
        tests_run++;
        if (to || res !== 9'h132) begin
            fails++;
            $display("FAIL operand_change: got %h, want 132", res);
        end
        tick();
    endtask

    task automatic test_random8();
        logic [8:0] res, exp; logic [7:0] ra, rb; logic rc; int lat, bn; bit to;
        int bad_sum = 0, bad_lat = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp = 9'(ra) + 9'(rb) + 9'(rc);
            do_op8(ra, rb, rc, 1'b0, 1'b0, res, lat, bn, to);
            if (to || res !== exp) begin
                bad_sum++;
                if (bad_sum <= 3)
                    $display("FAIL random8_sum: %h+%h+%b got %h, want %h", ra, rb, rc, res, exp);
            end
            if (lat !== 8) bad_lat++;
            if (to) break;
            if ($urandom_range(1, 0) == 1) tick();
            tick();
        end
        tests_run++;
        if (bad_sum !== 0) fails++;
        tests_run++;
        if (bad_lat !== 0) begin
            fails++;
            $display("FAIL random8_latency: got %0d wrong latencies, want 0", bad_lat);
        end
    endtask

    task automatic test_random16();
        logic [16:0] exp, res; logic [15:0] ra, rb; logic rc;
        int lat, bad_sum = 0, bad_lat = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            exp = 17'(ra) + 17'(rb) + 17'(rc);
            a16 = ra; b16 = rb; cin16 = rc; start16 = 1'b1;
            tick();
            start16 = 1'b0;
            a16 = ~ra;
            lat = 0;
            while (!done16 && lat <= 60) begin
                tick();
                lat++;
            end
            res = {cout16, sum16};
            if (res !== exp) begin
                bad_sum++;
                if (bad_sum <= 3)
                    $display("FAIL random16_sum: %h+%h+%b got %h, want %h", ra, rb, rc, res, exp);
            end
            if (lat !== 16) bad_lat++;
            if (lat > 60) break;
            tick();
        end
        tests_run++;
        if (bad_sum !== 0) fails++;
        tests_run++;
        if (bad_lat !== 0) begin
            fails++;
            $display("FAIL random16_latency: got %0d wrong latencies, want 0", bad_lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_ripple();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_operand_change();
        test_random8();
        test_random16();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
